// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller: state encoding, PC width
// and default bubble count / sequential PC increment.
package fetch_ctrl_pkg;

    localparam int PC_W              = 8;
    localparam int FLUSH_CYCLES_DEF  = 2;
    localparam int PC_STEP_DEF       = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/flush_counter.sv
// 3-bit loadable down-counter with zero flag; counts the bubble cycles
// remaining after a taken branch.
module flush_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] loadVal,
    input  logic       dec,
    output logic [2:0] count,
    output logic       zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 3'd0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && count != 3'd0) begin
            count <= count - 3'd1;
        end
    end

    assign zero = (count == 3'd0);

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage PC/pipeline controller: branch redirect with IF/ID bubbles,
// decode-hazard stall, and halt/resume, plus a shadow copy of the fetch PC.
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int PC_STEP      = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branchTaken,
    input  logic [PC_W-1:0] branchTarget,
    input  logic            stallReq,
    input  logic            haltReq,
    input  logic            resumeReq,
    output logic            pcWrEn,
    output logic [PC_W-1:0] newPc,
    output logic            flushIfId,
    output logic            flushIdEx,
    output logic            stallIfId,
    output logic [PC_W-1:0] pcShadow,
    output logic [1:0]      ctrlState
);

    ctrl_state_t state, state_nxt;
    logic        cnt_load, cnt_dec, cnt_zero;
    logic [2:0]  cnt;

    flush_counter u_flush_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .loadVal (3'(FLUSH_CYCLES)),
        .dec     (cnt_dec),
        .count   (cnt),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            pcShadow <= '0;
        end else begin
            state    <= state_nxt;
            pcShadow <= pcWrEn ? newPc : pcShadow + PC_W'(PC_STEP);
        end
    end

    always_comb begin
        state_nxt = state;
        pcWrEn    = 1'b0;
        newPc     = pcShadow;
        flushIfId = 1'b0;
        flushIdEx = 1'b0;
        stallIfId = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        unique case (state)
            ST_RUN, ST_STALL: begin
                if (branchTaken) begin
                    pcWrEn    = 1'b1;
                    newPc     = branchTarget;
                    flushIfId = 1'b1;
                    flushIdEx = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = ST_FLUSH;
                // haltReq is only honoured from RUN; a halt seen while stalled is dropped
                end else if (haltReq && state == ST_RUN) begin
                    pcWrEn    = 1'b1;
                    stallIfId = 1'b1;
                    state_nxt = ST_HALT;
                end else if (stallReq) begin
                    pcWrEn    = 1'b1;
                    stallIfId = 1'b1;
                    state_nxt = ST_STALL;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // requests arriving now belong to squashed instructions
                flushIfId = 1'b1;
                cnt_dec   = 1'b1;
                if (cnt == 3'd1 || cnt_zero) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                pcWrEn    = 1'b1;
                stallIfId = 1'b1;
                if (resumeReq) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign ctrlState = state;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus randomized traffic
// checked against a behavioural model of the controller rules.
module tb_fetch_controller;

    localparam int FLUSH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       branchTaken, stallReq, haltReq, resumeReq;
    logic [7:0] branchTarget;
    logic       pcWrEn, flushIfId, flushIdEx, stallIfId;
    logic [7:0] newPc, pcShadow;
    logic [1:0] ctrlState;

    int tests_run = 0;
    int fails     = 0;

    fetch_controller #(.FLUSH_CYCLES(FLUSH), .PC_STEP(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .stallReq     (stallReq),
        .haltReq      (haltReq),
        .resumeReq    (resumeReq),
        .pcWrEn       (pcWrEn),
        .newPc        (newPc),
        .flushIfId    (flushIfId),
        .flushIdEx    (flushIdEx),
        .stallIfId    (stallIfId),
        .pcShadow     (pcShadow),
        .ctrlState    (ctrlState)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        branchTaken  = 1'b0;
        branchTarget = 8'h00;
        stallReq     = 1'b0;
        haltReq      = 1'b0;
        resumeReq    = 1'b0;
    endtask

    // Leaves the bench at a negedge, reset released, pcShadow = 0.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic go_pc(input logic [7:0] pc);
        do_reset();
        repeat (int'(pc) / 4) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        tests_run++;
        if ({pcWrEn, flushIfId, flushIdEx, stallIfId} !== 4'b0000) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 0000", {pcWrEn, flushIfId, flushIdEx, stallIfId});
        end
        tests_run++;
        if (newPc !== 8'h00 || pcShadow !== 8'h00 || ctrlState !== 2'd0) begin
            fails++; $display("FAIL reset_state: newPc=%h pc=%h st=%0d expected 00 00 0", newPc, pcShadow, ctrlState);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_idle();
        logic [7:0] exp_pc;
        exp_pc = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (pcShadow !== exp_pc || pcWrEn !== 1'b0) begin
                fails++; $display("FAIL idle_%0d: pc=%h we=%b expected pc=%h we=0", i, pcShadow, pcWrEn, exp_pc);
            end
            exp_pc = exp_pc + 8'h04;
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [7:0] exp_pc;
        go_pc(8'h10);
        branchTaken = 1'b1; branchTarget = 8'h40;
        #1;
        tests_run++;
        if (pcShadow !== 8'h10 || pcWrEn !== 1'b1 || newPc !== 8'h40 || flushIfId !== 1'b1 || flushIdEx !== 1'b1) begin
            fails++; $display("FAIL branch_cycle: pc=%h we=%b np=%h fi=%b fe=%b expected 10 1 40 1 1",
                              pcShadow, pcWrEn, newPc, flushIfId, flushIdEx);
        end
        @(negedge clk);
        idle_inputs();
        exp_pc = 8'h40;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (pcShadow !== exp_pc || flushIfId !== 1'b1 || pcWrEn !== 1'b0 || ctrlState !== 2'd2) begin
                fails++; $display("FAIL branch_flush_%0d: pc=%h fi=%b we=%b st=%0d expected %h 1 0 2",
                                  i, pcShadow, flushIfId, pcWrEn, ctrlState, exp_pc);
            end
            exp_pc = exp_pc + 8'h04;
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (pcShadow !== 8'h48 || flushIfId !== 1'b0 || ctrlState !== 2'd0) begin
            fails++; $display("FAIL branch_done: pc=%h fi=%b st=%0d expected 48 0 0", pcShadow, flushIfId, ctrlState);
        end
    endtask

    task automatic test_stall();
        go_pc(8'h20);
        stallReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (pcShadow !== 8'h20 || newPc !== 8'h20 || pcWrEn !== 1'b1 || stallIfId !== 1'b1) begin
                fails++; $display("FAIL stall_%0d: pc=%h np=%h we=%b si=%b expected 20 20 1 1",
                                  i, pcShadow, newPc, pcWrEn, stallIfId);
            end
            @(negedge clk);
        end
        stallReq = 1'b0;
        #1;
        tests_run++;
        if (pcShadow !== 8'h20 || pcWrEn !== 1'b0 || stallIfId !== 1'b0 || ctrlState !== 2'd1) begin
            fails++; $display("FAIL stall_release: pc=%h we=%b si=%b st=%0d expected 20 0 0 1",
                              pcShadow, pcWrEn, stallIfId, ctrlState);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (pcShadow !== 8'h24 || ctrlState !== 2'd0) begin
            fails++; $display("FAIL stall_after: pc=%h st=%0d expected 24 0", pcShadow, ctrlState);
        end
    endtask

    task automatic test_stall_branch();
        go_pc(8'h08);
        stallReq = 1'b1; branchTaken = 1'b1; branchTarget = 8'h80;
        #1;
        tests_run++;
        if (newPc !== 8'h80 || pcWrEn !== 1'b1 || stallIfId !== 1'b0) begin
            fails++; $display("FAIL stall_branch: np=%h we=%b si=%b expected 80 1 0", newPc, pcWrEn, stallIfId);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (ctrlState !== 2'd2 || pcShadow !== 8'h80) begin
            fails++; $display("FAIL stall_branch_state: st=%0d pc=%h expected 2 80", ctrlState, pcShadow);
        end
    endtask

    task automatic test_halt();
        go_pc(8'h30);
        haltReq = 1'b1;
        #1;
        tests_run++;
        if (pcWrEn !== 1'b1 || newPc !== 8'h30 || stallIfId !== 1'b1) begin
            fails++; $display("FAIL halt_entry: we=%b np=%h si=%b expected 1 30 1", pcWrEn, newPc, stallIfId);
        end
        @(negedge clk);
        haltReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            branchTaken = (i % 2 == 0); branchTarget = 8'h99;
            #1;
            tests_run++;
            if (ctrlState !== 2'd3 || pcShadow !== 8'h30 || newPc !== 8'h30 || flushIfId !== 1'b0) begin
                fails++; $display("FAIL halt_hold_%0d: st=%0d pc=%h np=%h fi=%b expected 3 30 30 0",
                                  i, ctrlState, pcShadow, newPc, flushIfId);
            end
            @(negedge clk);
        end
        idle_inputs();
        resumeReq = 1'b1;
        #1;
        tests_run++;
        if (pcShadow !== 8'h30 || pcWrEn !== 1'b1 || newPc !== 8'h30) begin
            fails++; $display("FAIL halt_resume: pc=%h we=%b np=%h expected 30 1 30", pcShadow, pcWrEn, newPc);
        end
        @(negedge clk);
        resumeReq = 1'b0;
        #1;
        tests_run++;
        if (pcShadow !== 8'h30 || ctrlState !== 2'd0) begin
            fails++; $display("FAIL halt_after: pc=%h st=%0d expected 30 0", pcShadow, ctrlState);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (pcShadow !== 8'h34) begin
            fails++; $display("FAIL halt_advance: pc=%h expected 34", pcShadow);
        end
    endtask

    task automatic test_wrap_reset();
        go_pc(8'hFC);
        #1;
        tests_run++;
        if (pcShadow !== 8'hFC) begin
            fails++; $display("FAIL wrap_pre: pc=%h expected fc", pcShadow);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (pcShadow !== 8'h00) begin
            fails++; $display("FAIL wrap: pc=%h expected 00", pcShadow);
        end
        branchTaken = 1'b1; branchTarget = 8'h50;
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (ctrlState !== 2'd2) begin
            fails++; $display("FAIL flush_entry: st=%0d expected 2", ctrlState);
        end
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if (ctrlState !== 2'd0 || pcShadow !== 8'h00 || flushIfId !== 1'b0 || pcWrEn !== 1'b0) begin
            fails++; $display("FAIL reset_mid_flush: st=%0d pc=%h fi=%b we=%b expected 0 00 0 0",
                              ctrlState, pcShadow, flushIfId, pcWrEn);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (pcShadow !== 8'h04 || ctrlState !== 2'd0) begin
            fails++; $display("FAIL reset_flush_resume: pc=%h st=%0d expected 04 0", pcShadow, ctrlState);
        end
        go_pc(8'h14);
        haltReq = 1'b1;
        @(negedge clk);
        haltReq = 1'b0;
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (ctrlState !== 2'd0 || pcShadow !== 8'h00 || stallIfId !== 1'b0) begin
            fails++; $display("FAIL reset_mid_halt: st=%0d pc=%h si=%b expected 0 00 0", ctrlState, pcShadow, stallIfId);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Behavioural model: bubbles left, halted/stalled flags, fetch PC.
    task automatic test_random();
        int         bubbles;
        bit         halted, stalled;
        logic [7:0] m_pc, e_np;
        logic       e_we, e_fi, e_fe, e_si;
        logic [1:0] e_st;
        do_reset();
        bubbles = 0; halted = 0; stalled = 0; m_pc = 8'h00;
        for (int cyc = 0; cyc < 600; cyc++) begin
            branchTaken  = ($urandom_range(0, 7) == 0);
            branchTarget = 8'($urandom_range(0, 63) * 4);
            stallReq     = ($urandom_range(0, 3) == 0);
            haltReq      = ($urandom_range(0, 7) == 0);
            resumeReq    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                #1;
                tests_run++;
                if (ctrlState !== 2'd0 || pcShadow !== 8'h00) begin
                    fails++; $display("FAIL rnd_reset_%0d: st=%0d pc=%h expected 0 00", cyc, ctrlState, pcShadow);
                end
                bubbles = 0; halted = 0; stalled = 0; m_pc = 8'h00;
                @(negedge clk);
                reset = 1'b1;
                continue;
            end
            e_st = halted ? 2'd3 : (bubbles > 0) ? 2'd2 : stalled ? 2'd1 : 2'd0;
            e_we = 0; e_np = m_pc; e_fi = 0; e_fe = 0; e_si = 0;
            if (bubbles > 0) begin
                e_fi = 1;
                bubbles--;
            end else if (halted) begin
                e_we = 1; e_si = 1;
                if (resumeReq) halted = 0;
            end else if (branchTaken) begin
                e_we = 1; e_np = branchTarget; e_fi = 1; e_fe = 1;
                bubbles = FLUSH; stalled = 0;
            end else if (haltReq && !stalled) begin
                e_we = 1; e_si = 1; halted = 1;
            end else if (stallReq) begin
                e_we = 1; e_si = 1; stalled = 1;
            end else begin
                stalled = 0;
            end
            #1;
            tests_run++;
            if (ctrlState !== e_st || pcShadow !== m_pc) begin
                fails++; $display("FAIL rnd_state_%0d: st=%0d pc=%h expected %0d %h", cyc, ctrlState, pcShadow, e_st, m_pc);
            end
            tests_run++;
            if ({pcWrEn, flushIfId, flushIdEx, stallIfId} !== {e_we, e_fi, e_fe, e_si}) begin
                fails++; $display("FAIL rnd_ctrl_%0d: got %b expected %b", cyc,
                                  {pcWrEn, flushIfId, flushIdEx, stallIfId}, {e_we, e_fi, e_fe, e_si});
            end
            if (e_we) begin
                tests_run++;
                if (newPc !== e_np) begin
                    fails++; $display("FAIL rnd_newpc_%0d: got %h expected %h", cyc, newPc, e_np);
                end
            end
            m_pc = e_we ? e_np : m_pc + 8'h04;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_idle();
        test_branch();
        test_stall();
        test_stall_branch();
        test_halt();
        test_wrap_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of bubble cycles injected into IF/ID after a taken branch (legal 1..7).
REQ-002 SHALL have parameter PC_STEP, default 4, sequential PC increment, equal to the fetch-stage increment.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 branchTaken  in  1  execute stage resolved a taken branch/jump this cycle.
REQ-006 branchTarget  in  8  byte address of the branch destination.
REQ-007 stallReq  in  1  decode hazard unit requests a fetch hold this cycle.
REQ-008 haltReq  in  1  one-cycle pulse: halt instruction decoded.
REQ-009 resumeReq  in  1  one-cycle pulse: leave halt.
REQ-010 pcWrEn  out  1  drives the fetch-stage PC-mux select.
REQ-011 newPc  out  8  PC value loaded when pcWrEn=1.
REQ-012 flushIfId  out  1  clear IF/ID pipeline register.
REQ-013 flushIdEx  out  1  clear ID/EX pipeline register.
REQ-014 stallIfId  out  1  hold IF/ID pipeline register.
REQ-015 pcShadow  out  8  registered copy of the fetch-stage PC.
REQ-016 ctrlState  out  2  current state encoding (RUN=0, STALL=1, FLUSH=2, HALT=3).

Function
REQ-017 SHALL implement states RUN, STALL, FLUSH, HALT; pcWrEn, newPc and all flush/stall outputs are combinational from state and inputs.
REQ-018 pcShadow SHALL update every clock: next = pcWrEn ? newPc : pcShadow+PC_STEP, modulo 256 (0xFC+4 -> 0x00), tracking the fetch PC exactly.
REQ-019 RUN, no request: pcWrEn=0, all flush/stall outputs 0.
REQ-020 RUN or STALL with branchTaken=1 (highest priority): pcWrEn=1, newPc=branchTarget, flushIfId=1, flushIdEx=1; next state FLUSH with counter loaded to FLUSH_CYCLES.
REQ-021 FLUSH: flushIfId=1, pcWrEn=0 (PC advances); counter decrements each cycle; at counter=1 next state RUN; branchTaken, stallReq and haltReq SHALL be ignored (squashed instructions).
REQ-022 RUN with haltReq=1 and no branch: pcWrEn=1, newPc=pcShadow (hold), stallIfId=1; next state HALT.
REQ-023 HALT: pcWrEn=1, newPc=pcShadow, stallIfId=1; branchTaken and stallReq ignored; resumeReq=1 -> next state RUN, PC still held that cycle.
REQ-024 RUN with stallReq=1, no branch, no halt: pcWrEn=1, newPc=pcShadow, stallIfId=1; next state STALL.
REQ-025 STALL: while stallReq=1 hold as REQ-024; stallReq=0 -> outputs as RUN (PC advances this cycle), next state RUN; haltReq in STALL takes effect only after returning to RUN.
REQ-026 Priority within a cycle: branchTaken > haltReq > stallReq.
REQ-027 resumeReq outside HALT and haltReq outside RUN SHALL have no effect.

Reset
REQ-028 reset=0 SHALL asynchronously force state RUN, pcShadow=0x00, flush counter=0; outputs then pcWrEn=0, newPc=0x00, all flush/stall=0, ctrlState=0.
REQ-029 Reset asserted mid-FLUSH or mid-HALT SHALL abandon that state; first cycle after release behaves as RUN from PC 0x00.

Structure
REQ-030 Shared package fetch_ctrl_pkg SHALL hold the state enum, PC_W=8 and default FLUSH_CYCLES/PC_STEP constants.
REQ-031 The flush counter SHALL be one sub-module, flush_counter (3-bit loadable down-counter with zero flag); the rest is a single FSM process plus combinational output logic.

Verification
REQ-032 Reset release, idle 5 cycles -> pcWrEn=0 throughout, pcShadow 0x00,0x04,0x08,0x0C,0x10.
REQ-033 pcShadow=0x10, branchTaken=1, branchTarget=0x40 -> that cycle pcWrEn=1, newPc=0x40, both flushes=1; next 2 cycles flushIfId=1; pcShadow 0x40,0x44,0x48; then RUN.
REQ-034 stallReq high 3 cycles at pcShadow=0x20 -> newPc=0x20 and stallIfId=1 for 3 cycles; pcShadow stays 0x20, then 0x24.
REQ-035 stallReq=1 and branchTaken=1 together (target 0x80) -> branch wins, newPc=0x80, state FLUSH, stallIfId=0.
REQ-036 haltReq at pcShadow=0x30, branchTaken pulses during HALT, resumeReq after 4 cycles -> PC held at 0x30 throughout, branch ignored, then 0x34.
REQ-037 pcShadow=0xFC idle -> next 0x00; reset=0 asserted mid-FLUSH -> immediate ctrlState=0, pcShadow=0x00.
